// File: rtl/out_wr_arb_pkg.sv
// Shared definitions for the out_wr_arbiter block: arbiter FSM encoding and
// line geometry helpers used to turn a line count into a byte offset.
package out_wr_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_t;

   localparam int DEF_DATA_W = 512;
   localparam int LINE_BYTES = DEF_DATA_W / 8;
   localparam int LINE_SHIFT = $clog2(LINE_BYTES);

   // Shift that converts a line index into a byte offset for a given line width
   function automatic int line_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/out_wr_arbiter_rr.sv
// Combinational round-robin picker: returns the first requester strictly
// after ptr (wrapping NUM_CH-1 -> 0) as both a one-hot vector and an index.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
)(
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              any_req
);

   // Scan offsets from farthest to nearest so the nearest requester wins
   always_comb begin
      int cand;
      cand      = 0;
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      for (int off = NUM_CH; off >= 1; off--) begin
         cand = (int'(ptr) + off) % NUM_CH;
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/out_wr_arbiter.sv
// out_wr_arbiter: shares one wide memory write port among NUM_CH channels.
// Each channel owns a one-line buffer; full buffers are issued round-robin,
// back-to-back when possible, at base + line_count * line_bytes.
// Optional statistics ports are built when OUT_WR_ARB_STATS_EN is defined.
module out_wr_arbiter
   import out_wr_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 512,
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic [NUM_CH*ADDR_W-1:0] ch_base_addr,
   input  logic [NUM_CH-1:0]        ch_req_wr_data,
   input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
   input  logic [NUM_CH-1:0]        ch_done,
   output logic [NUM_CH-1:0]        ch_available_write,
   output logic                     mem_wr_valid,
   input  logic                     mem_wr_ready,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic [DATA_W-1:0]        mem_wr_data,
   output logic                     done,
   output logic [NUM_CH-1:0]        overflow_err
`ifdef OUT_WR_ARB_STATS_EN
   ,
   output logic [NUM_CH*CNT_W-1:0]  stat_lines,
   output logic [NUM_CH*CNT_W-1:0]  stat_stall
`endif
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SHIFT = line_shift(DATA_W);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0] grant_oh_q, grant_oh_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;

   logic [NUM_CH-1:0] buf_full;
   logic [NUM_CH-1:0] en_vec;
   logic [NUM_CH-1:0] arb_req;
   logic [NUM_CH-1:0] arb_grant;
   logic [IDX_W-1:0]  arb_idx;
   logic [IDX_W-1:0]  arb_ptr;
   logic              arb_any;
   logic              fire;
   logic              load;
   logic              start_ok;
   logic              all_done;

   logic [DATA_W-1:0] line_arr [NUM_CH];
   logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
   logic [ADDR_W-1:0] base_arr [NUM_CH];

   assign fire     = mem_wr_valid & mem_wr_ready;
   // A new run may only begin once nothing is buffered or in flight
   assign start_ok = start & (state_q == ST_IDLE) & ~(|buf_full);
   // While firing, the granted buffer is being emptied, so exclude it and
   // search from it so the next grant is the following channel
   assign arb_req  = fire ? (buf_full & ~grant_oh_q) : buf_full;
   assign arb_ptr  = fire ? grant_q : rr_ptr_q;
   assign load     = arb_any & ((state_q == ST_IDLE) | fire);
   assign all_done = &(ch_done | ~en_vec);

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr (
      .req       (arb_req),
      .ptr       (arb_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   // Per-channel line buffer, enable/base latch, line counter and overflow flag
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic              full_q, full_d;
      logic              ovf_q, ovf_d;
      logic              en_q, en_d;
      logic [DATA_W-1:0] line_q, line_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [ADDR_W-1:0] base_q, base_d;
      logic              req_i;
      logic              fire_i;

      assign req_i  = ch_req_wr_data[gi] & en_q;
      assign fire_i = fire & grant_oh_q[gi];

      // Capture on request into an empty buffer, flag requests into a full one
      always_comb begin
         full_d = full_q;
         ovf_d  = ovf_q;
         en_d   = en_q;
         line_d = line_q;
         cnt_d  = cnt_q;
         base_d = base_q;
         if (req_i && !full_q) begin
            full_d = 1'b1;
            line_d = ch_wr_data[gi*DATA_W +: DATA_W];
         end
         if (req_i && full_q) begin
            ovf_d = 1'b1;
         end
         if (fire_i) begin
            full_d = 1'b0;
            cnt_d  = cnt_q + 1'b1;
         end
         if (start_ok) begin
            en_d   = ch_en[gi];
            base_d = ch_base_addr[gi*ADDR_W +: ADDR_W];
            cnt_d  = '0;
         end
      end

      // Channel state registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            en_q   <= 1'b0;
            line_q <= '0;
            cnt_q  <= '0;
            base_q <= '0;
         end else begin
            full_q <= full_d;
            ovf_q  <= ovf_d;
            en_q   <= en_d;
            line_q <= line_d;
            cnt_q  <= cnt_d;
            base_q <= base_d;
         end
      end

      assign buf_full[gi]           = full_q;
      assign en_vec[gi]             = en_q;
      assign line_arr[gi]           = line_q;
      assign cnt_arr[gi]            = cnt_q;
      assign base_arr[gi]           = base_q;
      assign overflow_err[gi]       = ovf_q;
      assign ch_available_write[gi] = en_q & ~full_q & ~ch_req_wr_data[gi];

`ifdef OUT_WR_ARB_STATS_EN
      logic [CNT_W-1:0] stall_q, stall_d;

      // Count cycles a line waited without being accepted; saturate at all-ones
      always_comb begin
         stall_d = stall_q;
         if (start_ok) begin
            stall_d = '0;
         end else if (full_q && !fire_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
         end
      end

      // Stall counter register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stall_q <= '0;
         end else begin
            stall_q <= stall_d;
         end
      end

      assign stat_lines[gi*CNT_W +: CNT_W] = cnt_q;
      assign stat_stall[gi*CNT_W +: CNT_W] = stall_q;
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: leave IDLE on any full buffer, return when nothing is left
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (arb_any) state_d = ST_ISSUE;
         ST_ISSUE: if (fire && !arb_any) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      mem_wr_valid = (state_q == ST_ISSUE);
   end

   // Grant, address/data load, round-robin pointer and done aggregation
   always_comb begin
      grant_d    = grant_q;
      grant_oh_d = grant_oh_q;
      rr_ptr_d   = rr_ptr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      done_d     = done_q;
      if (fire) begin
         rr_ptr_d = grant_q;
      end
      if (load) begin
         grant_d    = arb_idx;
         grant_oh_d = arb_grant;
         addr_d     = base_arr[arb_idx] + (ADDR_W'(cnt_arr[arb_idx]) << SHIFT);
         data_d     = line_arr[arb_idx];
      end
      if (start_ok) begin
         done_d = 1'b0;
      end else if (all_done && !(|buf_full) && !mem_wr_valid && (|en_vec)) begin
         done_d = 1'b1;
      end
   end

   // Arbiter datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_ptr_q   <= IDX_W'(NUM_CH - 1);
         addr_q     <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         grant_q    <= grant_d;
         grant_oh_q <= grant_oh_d;
         rr_ptr_q   <= rr_ptr_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         done_q     <= done_d;
      end
   end

   assign mem_wr_addr = addr_q;
   assign mem_wr_data = data_q;
   assign done        = done_q;

endmodule

// File: tb/tb_out_wr_arbiter.sv
// Self-checking bench for out_wr_arbiter: expected lines are queued when a
// channel request is driven and compared when the memory port accepts them.
module tb_out_wr_arbiter;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 512;
   localparam int ADDR_W = 64;
   localparam int CNT_W  = 32;

   logic                     clk;
   logic                     rst_n;
   logic                     start;
   logic [NUM_CH-1:0]        ch_en;
   logic [NUM_CH*ADDR_W-1:0] ch_base_addr;
   logic [NUM_CH-1:0]        ch_req_wr_data;
   logic [NUM_CH*DATA_W-1:0] ch_wr_data;
   logic [NUM_CH-1:0]        ch_done;
   logic [NUM_CH-1:0]        ch_available_write;
   logic                     mem_wr_valid;
   logic                     mem_wr_ready;
   logic [ADDR_W-1:0]        mem_wr_addr;
   logic [DATA_W-1:0]        mem_wr_data;
   logic                     done;
   logic [NUM_CH-1:0]        overflow_err;
`ifdef OUT_WR_ARB_STATS_EN
   logic [NUM_CH*CNT_W-1:0]  stat_lines;
   logic [NUM_CH*CNT_W-1:0]  stat_stall;
`endif

   out_wr_arbiter #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .ch_en              (ch_en),
      .ch_base_addr       (ch_base_addr),
      .ch_req_wr_data     (ch_req_wr_data),
      .ch_wr_data         (ch_wr_data),
      .ch_done            (ch_done),
      .ch_available_write (ch_available_write),
      .mem_wr_valid       (mem_wr_valid),
      .mem_wr_ready       (mem_wr_ready),
      .mem_wr_addr        (mem_wr_addr),
      .mem_wr_data        (mem_wr_data),
      .done               (done),
      .overflow_err       (overflow_err)
`ifdef OUT_WR_ARB_STATS_EN
      ,
      .stat_lines         (stat_lines),
      .stat_stall         (stat_stall)
`endif
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                ch;
   } exp_t;

   exp_t              exp_q[$];
   int                fire_cyc[$];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_err = 0;
   logic [ADDR_W-1:0] base_m [NUM_CH];
   int                cnt_m  [NUM_CH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: inputs only change on negedges, so valid&ready seen just after
   // a negedge is exactly what the next posedge accepts
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n && mem_wr_valid && mem_wr_ready) begin
         fire_cyc.push_back(cyc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_line addr got %h required none", mem_wr_addr);
         end else begin
            e = exp_q.pop_front();
            if (mem_wr_addr !== e.addr || mem_wr_data !== e.data) begin
               n_err++;
               $display("FAIL sb_line ch%0d addr got %h required %h data[31:0] got %h required %h",
                        e.ch, mem_wr_addr, e.addr, mem_wr_data[31:0], e.data[31:0]);
            end else begin
               $display("line ch%0d addr %h data[31:0] %h ok", e.ch, mem_wr_addr, mem_wr_data[31:0]);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n          = 1'b0;
      start          = 1'b0;
      ch_en          = '0;
      ch_base_addr   = '0;
      ch_req_wr_data = '0;
      ch_wr_data     = '0;
      ch_done        = '0;
      mem_wr_ready   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_q.delete();
      fire_cyc.delete();
   endtask

   task automatic do_start(input logic [NUM_CH-1:0] en, input logic [ADDR_W-1:0] b0,
                           input logic [ADDR_W-1:0] b1, input logic [ADDR_W-1:0] b2,
                           input logic [ADDR_W-1:0] b3);
      @(negedge clk);
      ch_en        = en;
      ch_base_addr = {b3, b2, b1, b0};
      start        = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      base_m[0] = b0;
      base_m[1] = b1;
      base_m[2] = b2;
      base_m[3] = b3;
      for (int i = 0; i < NUM_CH; i++) cnt_m[i] = 0;
   endtask

   // Drive ch's request on the current negedge and queue its expected line
   task automatic drive_req(input int ch);
      logic [DATA_W-1:0] d;
      for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
      ch_wr_data[ch*DATA_W +: DATA_W] = d;
      ch_req_wr_data[ch] = 1'b1;
      exp_q.push_back('{addr: base_m[ch] + ADDR_W'(cnt_m[ch]) * 64, data: d, ch: ch});
      cnt_m[ch]++;
   endtask

   task automatic send_line(input int ch);
      int w;
      w = 0;
      @(negedge clk);
      while (!ch_available_write[ch] && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout ch%0d available_write got 0 required 1", ch);
      end else begin
         drive_req(ch);
         @(negedge clk);
         ch_req_wr_data[ch] = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout pending got %0d required 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid();
      int w;
      w = 0;
      while (!mem_wr_valid && w < 30) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (!mem_wr_valid) begin
         n_err++;
         $display("FAIL valid_timeout mem_wr_valid got 0 required 1");
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (mem_wr_valid !== 1'b0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
         n_err++;
         $display("FAIL reset_mem valid/addr got %b/%h required 0/0", mem_wr_valid, mem_wr_addr);
      end
      n_cmp++;
      if (done !== 1'b0 || overflow_err !== '0 || ch_available_write !== '0) begin
         n_err++;
         $display("FAIL reset_flags done/ovf/avail got %b/%b/%b required 0/0000/0000",
                  done, overflow_err, ch_available_write);
      end
   endtask

   task automatic test_single_channel();
      do_reset();
      do_start(4'b0001, 64'h1000, 64'h0, 64'h0, 64'h0);
      mem_wr_ready = 1'b1;
      @(negedge clk);
      drive_req(0);
      @(negedge clk);
      ch_req_wr_data[0] = 1'b0;
      n_cmp++;
      if (mem_wr_valid !== 1'b0 || ch_available_write[0] !== 1'b0) begin
         n_err++;
         $display("FAIL latency_t1 valid/avail0 got %b/%b required 0/0", mem_wr_valid, ch_available_write[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 64'h1000) begin
         n_err++;
         $display("FAIL latency_t2 valid/addr got %b/%h required 1/1000", mem_wr_valid, mem_wr_addr);
      end
      send_line(0);
      send_line(0);
      wait_drain();
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL done_early done got %b required 0", done);
      end
      ch_done[0] = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL done_set done got %b required 1", done);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_start(4'b1111, 64'h0, 64'h10000, 64'h20000, 64'h30000);
      mem_wr_ready = 1'b1;
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) drive_req(c);
      @(negedge clk);
      ch_req_wr_data = '0;
      wait_drain();
      n_cmp++;
      if (fire_cyc.size() != 4 || (fire_cyc[3] - fire_cyc[0]) != 3) begin
         n_err++;
         $display("FAIL back_to_back fires/span got %0d/%0d required 4/3",
                  fire_cyc.size(), (fire_cyc.size() == 4) ? fire_cyc[3] - fire_cyc[0] : -1);
      end
   endtask

   task automatic test_stall_overflow();
      logic [ADDR_W-1:0] a0;
      logic [DATA_W-1:0] d0;
      int                bad;
      do_reset();
      do_start(4'b0010, 64'h0, 64'h2000, 64'h0, 64'h0);
      send_line(1);
      wait_valid();
      a0 = mem_wr_addr;
      d0 = mem_wr_data;
      n_cmp++;
      if (a0 !== 64'h2000) begin
         n_err++;
         $display("FAIL stall_addr addr got %h required 2000", a0);
      end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_wr_valid !== 1'b1 || mem_wr_addr !== a0 || mem_wr_data !== d0 || ch_available_write[1] !== 1'b0)
            bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL stall_stable unstable cycles got %0d required 0", bad);
      end
      n_cmp++;
      if (overflow_err !== 4'b0000) begin
         n_err++;
         $display("FAIL ovf_before overflow_err got %b required 0000", overflow_err);
      end
      ch_wr_data[DATA_W +: DATA_W] = {16{32'hdeadbeef}};
      ch_req_wr_data[1] = 1'b1;
      @(negedge clk);
      ch_req_wr_data[1] = 1'b0;
      n_cmp++;
      if (overflow_err !== 4'b0010) begin
         n_err++;
         $display("FAIL ovf_set overflow_err got %b required 0010", overflow_err);
      end
      mem_wr_ready = 1'b1;
      wait_drain();
      n_cmp++;
      if (overflow_err !== 4'b0010 || fire_cyc.size() != 1) begin
         n_err++;
         $display("FAIL ovf_hold ovf/lines got %b/%0d required 0010/1", overflow_err, fire_cyc.size());
      end
   endtask

   task automatic test_wrap_fairness();
      do_reset();
      do_start(4'b0101, 64'h4000, 64'h0, 64'h8000, 64'h0);
      mem_wr_ready = 1'b1;
      send_line(2);
      wait_drain();
      mem_wr_ready = 1'b0;
      @(negedge clk);
      drive_req(0);
      drive_req(2);
      @(negedge clk);
      ch_req_wr_data = '0;
      wait_valid();
      n_cmp++;
      if (mem_wr_addr !== 64'h4000) begin
         n_err++;
         $display("FAIL wrap_first addr got %h required 4000", mem_wr_addr);
      end
      mem_wr_ready = 1'b1;
      wait_drain();
   endtask

   task automatic test_async_reset();
      do_reset();
      do_start(4'b0001, 64'h1000, 64'h0, 64'h0, 64'h0);
      ch_done[0] = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_done done got %b required 1", done);
      end
      send_line(0);
      wait_valid();
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_wr_valid !== 1'b0 || done !== 1'b0 || mem_wr_addr !== '0 || mem_wr_data !== '0) begin
         n_err++;
         $display("FAIL async_reset valid/done/addr got %b/%b/%h required 0/0/0",
                  mem_wr_valid, done, mem_wr_addr);
      end
      exp_q.delete();
      fire_cyc.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ch_available_write !== 4'b0000) begin
         n_err++;
         $display("FAIL post_reset_avail got %b required 0000", ch_available_write);
      end
      do_start(4'b0001, 64'h1000, 64'h0, 64'h0, 64'h0);
      mem_wr_ready = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (fire_cyc.size() != 0 || mem_wr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stale_line lines/valid got %0d/%b required 0/0", fire_cyc.size(), mem_wr_valid);
      end
   endtask

   task automatic test_start_busy();
      do_reset();
      do_start(4'b0001, 64'h3000, 64'h0, 64'h0, 64'h0);
      mem_wr_ready = 1'b1;
      send_line(0);
      wait_drain();
      mem_wr_ready = 1'b0;
      send_line(0);
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k == 0) begin
            ch_en                = 4'b0011;
            ch_base_addr[63:0]   = 64'h5000;
            start                = 1'b1;
         end else if (k == 1) begin
            start = 1'b0;
         end
      end
      mem_wr_ready = 1'b1;
      wait_drain();
`ifdef OUT_WR_ARB_STATS_EN
      n_cmp++;
      if (stat_stall[CNT_W-1:0] !== 32'd12 || stat_lines[CNT_W-1:0] !== 32'd2) begin
         n_err++;
         $display("FAIL stats stall/lines got %0d/%0d required 12/2",
                  stat_stall[CNT_W-1:0], stat_lines[CNT_W-1:0]);
      end
`endif
      n_cmp++;
      if (ch_available_write[1] !== 1'b0) begin
         n_err++;
         $display("FAIL busy_start_en avail1 got %b required 0", ch_available_write[1]);
      end
      send_line(0);
      wait_drain();
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_single_channel();
      test_back_to_back();
      test_stall_overflow();
      test_wrap_fairness();
      test_async_reset();
      test_start_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
